// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package ifetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          DEF_DEPTH = 4;
  localparam int          CNT_W     = $clog2(DEF_DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Clear the byte-offset bits of a fetch address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Redirect, instruction-memory and decode-side signals of the prefetch queue.
// master: the prefetch unit; slave: the surrounding core/memory.
interface ifetch_queue_if;

  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    input  redirect_valid, redirect_pc,
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/ifetch_queue_fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} pairs. Flush has priority over
// push and pop in the same cycle.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output fetch_entry_t  head,
  output logic          empty
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: owns the sequential fetch address, issues
// in-order word requests, buffers responses and hands them to decode.
// The PC of a returning word is derived as fetch_pc - 4*outstanding, which
// holds because responses arrive in order and stale (pre-redirect) words are
// counted in discard and retired before any live one.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = DEF_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           clr,
  ifetch_queue_if.master bus
);

  localparam int            CW  = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   CAP = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;
  logic [CW:0]   occupancy;
  logic          mem_req;
  logic          gnt_fire, rsp_fire, rsp_keep, pop_fire;

  // Request issue, response acceptance and the PC of the returning word.
  always_comb begin
    occupancy        = {1'b0, fifo_count} + {1'b0, outstanding_q};
    mem_req          = clr & ~bus.redirect_valid & (occupancy < CAP);
    gnt_fire         = mem_req & bus.mem_gnt;
    rsp_fire         = bus.mem_rvalid & (outstanding_q != '0);
    rsp_keep         = rsp_fire & (discard_q == '0);
    push_entry.pc    = fetch_pc_q - 32'({outstanding_q, 2'b00});
    push_entry.instr = bus.mem_rdata;
    pop_fire         = ~fifo_empty & bus.instr_ready;
  end

  // Fetch address, in-flight and discard accounting; redirect overrides.
  always_comb begin
    outstanding_d = outstanding_q + CW'(gnt_fire) - CW'(rsp_fire);
    discard_d     = discard_q;
    fetch_pc_d    = fetch_pc_q;
    if (rsp_fire && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end
    if (gnt_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (bus.redirect_valid) begin
      discard_d  = outstanding_d;
      fetch_pc_d = word_align(bus.redirect_pc);
    end
  end

  // Address and counter registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clr       (clr),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (pop_fire),
    .flush     (bus.redirect_valid),
    .count     (fifo_count),
    .head      (fifo_head),
    .empty     (fifo_empty)
  );

  assign bus.mem_req     = mem_req;
  assign bus.mem_addr    = fetch_pc_q;
  assign bus.instr_valid = ~fifo_empty;
  assign bus.instr       = fifo_empty ? NOP_INSTR : fifo_head.instr;
  assign bus.instr_pc    = fifo_empty ? 32'h0 : fifo_head.pc;

endmodule
